// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared encodings for the multicycle ALU control sequencer
package alu_ctrl_pkg;

   // ALU operation codes driven on alu_ctrl
   typedef enum logic [3:0] {
      ALU_NOP  = 4'b0000,
      ALU_AND  = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_SUB  = 4'b0011,
      ALU_CMP  = 4'b0100,
      ALU_BEQ  = 4'b0101,
      ALU_SLL  = 4'b1100,
      ALU_SLR  = 4'b1101,
      ALU_SLLV = 4'b1110,
      ALU_SLRV = 4'b1111
   } alu_op_e;

   // Instruction opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_CMP   = 6'h10;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SLR  = 6'h02;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SLRV = 6'h06;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;

   // Sequencer states; the numeric values are visible on state_q
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_TRAP   = 3'd6
   } state_e;

   // Bit positions inside flags_q = {n,z,c,v}
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Opcodes the sequencer can execute (HALT is handled separately)
   function automatic logic opcode_known(input logic [5:0] op);
      logic known;
      case (op)
         OP_RTYPE, OP_BEQ, OP_ADDI, OP_ANDI,
         OP_CMP, OP_LW, OP_SW: known = 1'b1;
         default:              known = 1'b0;
      endcase
      return known;
   endfunction

endpackage

// File: rtl/alu_ctrl_fsm_if.sv
// rtl/alu_ctrl_fsm_if.sv - instruction, memory-handshake and ALU control/status bundle
interface alu_ctrl_fsm_if;

   // instruction register fields and memory handshake
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       mem_ready;

   // ALU status
   logic       alu_zero;
   logic       alu_negative;
   logic       alu_carry;
   logic       alu_overflow;

   // ALU control and operand selects
   logic [3:0] alu_ctrl;
   logic       alu_src_a;
   logic [1:0] alu_src_b;

   // datapath strobes and selects
   logic       pc_write;
   logic       pc_src;
   logic       ir_write;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       reg_write;
   logic       mem_to_reg;

   // sequencer side
   modport master (
      input  opcode, funct, mem_ready,
      input  alu_zero, alu_negative, alu_carry, alu_overflow,
      output alu_ctrl, alu_src_a, alu_src_b,
      output pc_write, pc_src, ir_write, iord,
      output mem_read, mem_write, reg_write, mem_to_reg
   );

   // datapath side
   modport slave (
      output opcode, funct, mem_ready,
      output alu_zero, alu_negative, alu_carry, alu_overflow,
      input  alu_ctrl, alu_src_a, alu_src_b,
      input  pc_write, pc_src, ir_write, iord,
      input  mem_read, mem_write, reg_write, mem_to_reg
   );

endinterface

// File: rtl/alu_func_decode.sv
// rtl/alu_func_decode.sv - R-type funct field to ALU operation decoder
module alu_func_decode
   import alu_ctrl_pkg::*;
(
   input  logic [5:0] funct,
   output alu_op_e    alu_ctrl,
   output logic       valid
);

   // map each supported funct to its ALU op; anything else is undefined
   always_comb begin
      alu_ctrl = ALU_NOP;
      valid    = 1'b1;
      case (funct)
         FN_AND:  alu_ctrl = ALU_AND;
         FN_ADD:  alu_ctrl = ALU_ADD;
         FN_SUB:  alu_ctrl = ALU_SUB;
         FN_SLL:  alu_ctrl = ALU_SLL;
         FN_SLR:  alu_ctrl = ALU_SLR;
         FN_SLLV: alu_ctrl = ALU_SLLV;
         FN_SLRV: alu_ctrl = ALU_SLRV;
         default: valid    = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// rtl/alu_ctrl_fsm.sv - multicycle ALU control sequencer; ALU_CTRL_TIMEOUT_EN adds a mem_ready wait timeout
module alu_ctrl_fsm
   import alu_ctrl_pkg::*;
#(
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   alu_ctrl_fsm_if.master   bus,
   output logic [3:0]       flags_q,
   output logic [2:0]       state_q,
   output logic [CNT_W-1:0] retired_cnt,
   output logic             illegal,
   output logic             bus_err
);

   state_e     state_r;
   alu_op_e    fn_op;
   logic       fn_valid;
   alu_op_e    exec_op;
   logic [1:0] exec_src_b;
   logic [3:0] flags_exec;
   logic       is_rtype;
   logic       is_lw;
   logic       is_sw;
   logic       op_legal;

   assign state_q  = state_r;
   assign is_rtype = (bus.opcode == OP_RTYPE);
   assign is_lw    = (bus.opcode == OP_LW);
   assign is_sw    = (bus.opcode == OP_SW);
   assign op_legal = opcode_known(bus.opcode) && (!is_rtype || fn_valid);

   alu_func_decode u_func_decode (
      .funct    (bus.funct),
      .alu_ctrl (fn_op),
      .valid    (fn_valid)
   );

   // ALU op and operand-B select for the instruction in EXEC
   always_comb begin
      exec_op    = ALU_ADD;
      exec_src_b = 2'b00;
      case (bus.opcode)
         OP_RTYPE: exec_op = fn_op;
         OP_ADDI:  exec_src_b = 2'b10;
         OP_ANDI: begin
            exec_op    = ALU_AND;
            exec_src_b = 2'b10;
         end
         OP_LW, OP_SW: exec_src_b = 2'b10;
         OP_BEQ:   exec_op = ALU_BEQ;
         OP_CMP:   exec_op = ALU_CMP;
         default:  exec_op = ALU_ADD;
      endcase
   end

   // flag value to latch at the end of EXEC: n/z always follow the ALU, c/v depend on the op class
   always_comb begin
      flags_exec         = flags_q;
      flags_exec[FLAG_N] = bus.alu_negative;
      flags_exec[FLAG_Z] = bus.alu_zero;
      if (bus.opcode == OP_CMP) begin
         flags_exec[FLAG_C] = bus.alu_carry;
      end else if ((bus.opcode == OP_ADDI) ||
                   (is_rtype && ((fn_op == ALU_ADD) || (fn_op == ALU_SUB)))) begin
         flags_exec[FLAG_C] = bus.alu_carry;
         flags_exec[FLAG_V] = bus.alu_overflow;
      end else if ((bus.opcode == OP_ANDI) || is_rtype) begin
         flags_exec[FLAG_C] = 1'b0;
         flags_exec[FLAG_V] = 1'b0;
      end
   end

   // datapath strobes decoded from the current state; all quiet while in reset
   always_comb begin
      bus.alu_ctrl   = ALU_NOP;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = 2'b00;
      bus.pc_write   = 1'b0;
      bus.pc_src     = 1'b0;
      bus.ir_write   = 1'b0;
      bus.iord       = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.reg_write  = 1'b0;
      bus.mem_to_reg = 1'b0;
      if (rst_n) begin
         case (state_r)
            S_FETCH: begin
               bus.mem_read  = 1'b1;
               bus.alu_src_b = 2'b01;
               bus.alu_ctrl  = ALU_ADD;
               bus.ir_write  = bus.mem_ready;
               bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
               bus.alu_src_b = 2'b11;
               bus.alu_ctrl  = ALU_ADD;
            end
            S_EXEC: begin
               bus.alu_src_a = 1'b1;
               bus.alu_src_b = exec_src_b;
               bus.alu_ctrl  = exec_op;
               if (bus.opcode == OP_BEQ) begin
                  bus.pc_src   = 1'b1;
                  bus.pc_write = bus.alu_zero;
               end
            end
            S_MEM: begin
               bus.iord      = 1'b1;
               bus.mem_read  = is_lw;
               bus.mem_write = is_sw;
            end
            S_WB: begin
               bus.reg_write  = 1'b1;
               bus.mem_to_reg = is_lw;
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_CTRL_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WAIT_W-1:0] wait_cnt;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign bus_err = 1'b0;
`endif

   // sequencer state, flag register, retire counter and sticky error bits
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= S_FETCH;
         flags_q     <= 4'b0000;
         retired_cnt <= '0;
         illegal     <= 1'b0;
`ifdef ALU_CTRL_TIMEOUT_EN
         bus_err     <= 1'b0;
         wait_cnt    <= '0;
`endif
      end else begin
         case (state_r)
            S_FETCH: begin
               if (bus.mem_ready) state_r <= S_DECODE;
            end
            S_DECODE: begin
               if (bus.opcode == OP_HALT) begin
                  state_r <= S_HALT;
               end else if (!op_legal) begin
                  state_r <= S_TRAP;
                  illegal <= 1'b1;
               end else begin
                  state_r <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (bus.opcode != OP_BEQ) flags_q <= flags_exec;
               if (is_lw || is_sw) begin
                  state_r <= S_MEM;
               end else if ((bus.opcode == OP_BEQ) || (bus.opcode == OP_CMP)) begin
                  state_r     <= S_FETCH;
                  retired_cnt <= retired_cnt + CNT_W'(1);
               end else begin
                  state_r <= S_WB;
               end
            end
            S_MEM: begin
               if (bus.mem_ready) begin
                  if (is_lw) begin
                     state_r <= S_WB;
                  end else begin
                     state_r     <= S_FETCH;
                     retired_cnt <= retired_cnt + CNT_W'(1);
                  end
               end
            end
            S_WB: begin
               state_r     <= S_FETCH;
               retired_cnt <= retired_cnt + CNT_W'(1);
            end
            S_HALT:  state_r <= S_HALT;
            S_TRAP:  state_r <= S_TRAP;
            default: state_r <= S_TRAP;
         endcase
`ifdef ALU_CTRL_TIMEOUT_EN
         // consecutive mem_ready-low cycles while waiting on memory; expiry overrides the case above
         if (((state_r == S_FETCH) || (state_r == S_MEM)) && !bus.mem_ready) begin
            if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
               wait_cnt <= '0;
               bus_err  <= 1'b1;
               state_r  <= S_TRAP;
            end else begin
               wait_cnt <= wait_cnt + WAIT_W'(1);
            end
         end else begin
            wait_cnt <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// tb/tb_alu_ctrl_fsm.sv - directed self-checking bench for alu_ctrl_fsm
module tb_alu_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  flags_q;
   logic [2:0]  state_q;
   logic [15:0] retired_cnt;
   logic        illegal;
   logic        bus_err;
   int          errors = 0;
   int          checks = 0;

   alu_ctrl_fsm_if bus_if ();

   alu_ctrl_fsm #(.CNT_W(16), .TIMEOUT_CYCLES(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus_if),
      .flags_q     (flags_q),
      .state_q     (state_q),
      .retired_cnt (retired_cnt),
      .illegal     (illegal),
      .bus_err     (bus_err)
   );

   always #5 clk = ~clk;

   wire [14:0] strobes = {bus_if.pc_write, bus_if.pc_src, bus_if.ir_write, bus_if.iord,
                          bus_if.mem_read, bus_if.mem_write, bus_if.reg_write, bus_if.mem_to_reg,
                          bus_if.alu_ctrl, bus_if.alu_src_a, bus_if.alu_src_b};

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_alu(input logic n, input logic z, input logic c, input logic v);
      bus_if.alu_negative = n;
      bus_if.alu_zero     = z;
      bus_if.alu_carry    = c;
      bus_if.alu_overflow = v;
   endtask

   initial begin
      rst_n            = 1'b0;
      bus_if.opcode    = 6'h00;
      bus_if.funct     = 6'h20;
      bus_if.mem_ready = 1'b1;
      set_alu(0, 0, 0, 0);
      tick();
      tick();
      // reset state
      chk("rst_state", state_q, 0);
      chk("rst_flags", flags_q, 0);
      chk("rst_cnt", retired_cnt, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_bus_err", bus_err, 0);
      chk("rst_strobes", strobes, 0);

      // 1: R-type ADD
      rst_n = 1'b1;
      #1;
      chk("add_fetch_memread", bus_if.mem_read, 1);
      chk("add_fetch_irwrite", bus_if.ir_write, 1);
      chk("add_fetch_alu", bus_if.alu_ctrl, 4'b0010);
      chk("add_fetch_srcb", bus_if.alu_src_b, 2'b01);
      tick();
      chk("add_decode_state", state_q, 1);
      chk("add_decode_srcb", bus_if.alu_src_b, 2'b11);
      tick();
      chk("add_exec_state", state_q, 2);
      chk("add_exec_alu", bus_if.alu_ctrl, 4'b0010);
      chk("add_exec_srca", bus_if.alu_src_a, 1);
      tick();
      chk("add_wb_state", state_q, 4);
      chk("add_wb_regwrite", bus_if.reg_write, 1);
      chk("add_wb_memtoreg", bus_if.mem_to_reg, 0);
      tick();
      chk("add_done_state", state_q, 0);
      chk("add_retired", retired_cnt, 1);

      // 2: LW with three wait cycles in MEM
      bus_if.opcode = 6'h23;
      tick();
      tick();
      chk("lw_exec_srcb", bus_if.alu_src_b, 2'b10);
      chk("lw_exec_alu", bus_if.alu_ctrl, 4'b0010);
      tick();
      for (int i = 0; i < 3; i++) begin
         bus_if.mem_ready = 1'b0;
         #1;
         chk("lw_mem_wait_state", state_q, 3);
         chk("lw_mem_wait_rd_iord", {bus_if.mem_read, bus_if.iord, bus_if.mem_write}, 3'b110);
         tick();
      end
      bus_if.mem_ready = 1'b1;
      #1;
      chk("lw_mem_last_state", state_q, 3);
      tick();
      chk("lw_wb_state", state_q, 4);
      chk("lw_wb_memtoreg", {bus_if.reg_write, bus_if.mem_to_reg}, 2'b11);
      tick();
      chk("lw_retired", retired_cnt, 2);

      // 3: BEQ taken then not taken
      bus_if.opcode = 6'h04;
      set_alu(0, 1, 0, 0);
      tick();
      tick();
      chk("beq_t_alu", bus_if.alu_ctrl, 4'b0101);
      chk("beq_t_pcsrc_pcwr", {bus_if.pc_src, bus_if.pc_write}, 2'b11);
      tick();
      chk("beq_t_state", state_q, 0);
      chk("beq_t_flags_kept", flags_q, 4'b0000);
      chk("beq_t_retired", retired_cnt, 3);
      set_alu(0, 0, 0, 0);
      tick();
      tick();
      chk("beq_nt_pcsrc_pcwr", {bus_if.pc_src, bus_if.pc_write}, 2'b10);
      tick();
      chk("beq_nt_state", state_q, 0);

      // 4: SUB flags then CMP keeps v
      bus_if.opcode = 6'h00;
      bus_if.funct  = 6'h22;
      set_alu(1, 0, 0, 1);
      tick();
      tick();
      chk("sub_exec_alu", bus_if.alu_ctrl, 4'b0011);
      tick();
      chk("sub_flags", flags_q, 4'b1001);
      tick();
      bus_if.opcode = 6'h10;
      set_alu(0, 1, 1, 0);
      tick();
      tick();
      chk("cmp_exec_alu", bus_if.alu_ctrl, 4'b0100);
      chk("cmp_no_regwrite", bus_if.reg_write, 0);
      tick();
      chk("cmp_flags", flags_q, 4'b0111);
      chk("cmp_state", state_q, 0);
      chk("cmp_retired", retired_cnt, 6);

      // shift clears c and v
      bus_if.opcode = 6'h00;
      bus_if.funct  = 6'h00;
      set_alu(0, 0, 1, 1);
      tick();
      tick();
      chk("sll_exec_alu", bus_if.alu_ctrl, 4'b1100);
      tick();
      chk("sll_flags", flags_q, 4'b0000);
      tick();

      // ADDI: immediate operand, c/v updated
      bus_if.opcode = 6'h08;
      set_alu(0, 0, 1, 1);
      tick();
      tick();
      chk("addi_exec_srcb", bus_if.alu_src_b, 2'b10);
      tick();
      chk("addi_flags", flags_q, 4'b0011);
      tick();
      chk("addi_retired", retired_cnt, 8);

      // reset mid-instruction aborts with no write strobe
      bus_if.funct  = 6'h20;
      bus_if.opcode = 6'h00;
      tick();
      tick();
      tick();
      chk("abort_in_wb", state_q, 4);
      rst_n = 1'b0;
      #1;
      chk("abort_strobes", strobes, 0);
      tick();
      chk("abort_state", state_q, 0);
      chk("abort_retired", retired_cnt, 0);
      rst_n = 1'b1;

      // 5: undefined opcode traps
      bus_if.opcode = 6'h3E;
      tick();
      tick();
      chk("trap_state", state_q, 6);
      chk("trap_illegal", illegal, 1);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("trap_hold_strobes", {state_q, strobes}, {3'd6, 15'd0});
      end
      rst_n = 1'b0;
      tick();
      chk("trap_rst_state", state_q, 0);
      chk("trap_rst_illegal", illegal, 0);
      rst_n = 1'b1;

      // undefined R-type funct traps too
      bus_if.opcode = 6'h00;
      bus_if.funct  = 6'h21;
      tick();
      tick();
      chk("badfn_state_illegal", {state_q, illegal}, {3'd6, 1'b1});
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;

      // HALT is absorbing and not illegal
      bus_if.opcode = 6'h3F;
      tick();
      tick();
      tick();
      chk("halt_state", state_q, 5);
      chk("halt_illegal", illegal, 0);
      chk("halt_strobes", strobes, 0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;

      // 6: memory never ready in FETCH
      bus_if.mem_ready = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      chk("to_15_state", state_q, 0);
      chk("to_15_bus_err", bus_err, 0);
      tick();
`ifdef ALU_CTRL_TIMEOUT_EN
      chk("to_16_state", state_q, 6);
      chk("to_16_bus_err", bus_err, 1);
`else
      chk("to_16_state", state_q, 0);
      chk("to_16_bus_err", bus_err, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
Multicycle control sequencer: the initiator side of the ALU interface. Drives the 4-bit ALU operation code and operand selects, and latches the ALU status flags (zero, negative, carry, overflow) into an architectural flag register. Steps each instruction through fetch/decode/execute/memory/writeback. Sits between the instruction register, register file, memory port and the 32-bit ALU.

Parameters:
CNT_W, 16, width of retired-instruction counter (wraps)
TIMEOUT_CYCLES, 16, mem_ready wait limit (used only with optional feature)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
mem_ready  in  1  memory access complete this cycle
alu_zero, alu_negative, alu_carry, alu_overflow  in  1 each  ALU status
alu_ctrl  out  4  ALU op: AND=0001 ADD=0010 SUB=0011 CMP=0100 BEQ=0101 SLL=1100 SLR=1101 SLLV=1110 SLRV=1111
alu_src_a  out  1  0=PC, 1=reg A
alu_src_b  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg  out  1 each  datapath strobes/selects
flags_q  out  4  {n,z,c,v} latched
state_q  out  3  current state
retired_cnt  out  CNT_W  completed instructions
illegal  out  1  sticky undefined opcode/funct
bus_err  out  1  sticky timeout (0 when feature off)

Behaviour:
- Single clock; reset is synchronous, active-low on rst_n. Reset: state FETCH, flags_q=0, retired_cnt=0, illegal=0, bus_err=0. Strobes are combinational from state and are forced 0 while rst_n=0.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6.
- FETCH: mem_read=1, iord=0, src_a=0, src_b=01, alu_ctrl=ADD. ir_write=pc_write=mem_ready, pc_src=0. Hold until mem_ready, then go to DECODE.
- DECODE, 1 cycle: src_a=0, src_b=11, ADD (branch target). Go to EXEC, HALT (opcode 3F) or TRAP (undefined opcode or R-type funct; set illegal).
- EXEC, 1 cycle:
  - R-type (op 00): src_a=1, src_b=00. funct 24→AND, 20→ADD, 22→SUB, 00→SLL, 02→SLR, 04→SLLV, 06→SLRV. Then WB.
  - ADDI (08) and ANDI (0C): src_b=10. Then WB.
  - LW (23) and SW (2B): ADD, src_b=10. Then MEM.
  - BEQ (04): src_a=1, src_b=00, alu_ctrl=BEQ, pc_src=1, pc_write=alu_zero. Then FETCH.
  - CMP (10): src_a=1, src_b=00, alu_ctrl=CMP, no writeback. Then FETCH.
- Flags latch at the EXEC clock edge for every EXEC op except BEQ.
  - n, z: always taken from the ALU.
  - c, v: updated only for ADD, SUB and ADDI. CMP updates c and keeps v. AND and shifts clear c and v.
- MEM: iord=1.
  - LW: mem_read until mem_ready, then WB.
  - SW: mem_write until mem_ready, then FETCH.
- WB, 1 cycle: reg_write=1, mem_to_reg=(LW). Then FETCH.
- retired_cnt increments by 1 on every transition into FETCH from EXEC, MEM or WB. Wraps modulo 2^CNT_W.
- HALT and TRAP are absorbing; only reset exits. All strobes are 0 in these states.
- rst_n low mid-instruction aborts it: no write strobes on that edge, next state FETCH.

Optional Feature:
ALU_CTRL_TIMEOUT_EN:
- When defined: a wait counter runs in FETCH and MEM, counting consecutive mem_ready=0 cycles and clearing on a state change.
- When the count reaches TIMEOUT_CYCLES: set bus_err, go to TRAP.
- When undefined: no counter is generated, bus_err is tied 0, and waits are unbounded.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALU op codes
  - opcode and funct constants
  - state encoding
  - flag bit indices
- One sub-module, alu_func_decode: combinational funct→{alu_ctrl, valid}, instantiated in the EXEC/DECODE path.

Test Plan:
1. Reset, mem_ready=1, R-type ADD (funct 20) → states 0,1,2,4,0. EXEC alu_ctrl=0010, WB reg_write=1, retired_cnt=1 after 4 cycles.
2. LW with mem_ready=0 for 3 MEM cycles → MEM held 4 cycles with mem_read=1, iord=1. Then WB with mem_to_reg=1; total 8 cycles.
3. BEQ with alu_zero=1 → EXEC alu_ctrl=0101, pc_src=1, pc_write=1, back to FETCH after 3 cycles. Repeat with alu_zero=0 → pc_write=0.
4. SUB with ALU n=1 z=0 c=0 v=1 → flags_q=4'b1001. Following CMP with v=0, c=1, n=0, z=1 → flags_q=4'b0111 (v kept).
5. opcode 3E → TRAP after DECODE, illegal=1, all strobes 0 for 10 cycles. rst_n=0 for one edge → state FETCH, illegal=0.
6. With ALU_CTRL_TIMEOUT_EN, mem_ready=0 in FETCH for 16 cycles → bus_err=1, state TRAP. Without the macro → still FETCH, bus_err=0.
